alu8_arbiter: RTL and testbench

//   Shares the single 8-bit add/sub ALU between two requesters (port 0: instruction

---
 rtl/alu8_arbiter_if.sv | 52 +++++
 rtl/alu8_arbiter.sv | 165 ++++++++++++++++
 tb/tb_alu8_arbiter.sv | 331 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu8_arbiter_if.sv
// Requester, response and ALU-side signals of alu8_arbiter.
// slave: the arbiter's view; master: the requesters plus the ALU driving it.
interface alu8_arbiter_if #(
  parameter int WIDTH = 8
);
  // requester 0 (instruction datapath)
  logic             req0_valid_i;
  logic             req0_op_i;
  logic [WIDTH-1:0] req0_a1_i;
  logic [WIDTH-1:0] req0_a0_i;
  logic             req0_ready_o;
  // requester 1 (address/pointer unit)
  logic             req1_valid_i;
  logic             req1_op_i;
  logic [WIDTH-1:0] req1_a1_i;
  logic [WIDTH-1:0] req1_a0_i;
  logic             req1_ready_o;
  // responses
  logic             rsp0_valid_o;
  logic             rsp0_ready_i;
  logic             rsp1_valid_o;
  logic             rsp1_ready_i;
  logic [WIDTH-1:0] rsp_r_o;
  logic             rsp_sign_o;
  // shared ALU
  logic [WIDTH-1:0] alu_a1_o;
  logic [WIDTH-1:0] alu_a0_o;
  logic             alu_add_o;
  logic             alu_sub_o;
  logic [WIDTH-1:0] alu_r_i;
  logic             alu_sign_i;

  modport slave (
    input  req0_valid_i, req0_op_i, req0_a1_i, req0_a0_i,
    input  req1_valid_i, req1_op_i, req1_a1_i, req1_a0_i,
    input  rsp0_ready_i, rsp1_ready_i,
    input  alu_r_i, alu_sign_i,
    output req0_ready_o, req1_ready_o,
    output rsp0_valid_o, rsp1_valid_o, rsp_r_o, rsp_sign_o,
    output alu_a1_o, alu_a0_o, alu_add_o, alu_sub_o
  );

  modport master (
    output req0_valid_i, req0_op_i, req0_a1_i, req0_a0_i,
    output req1_valid_i, req1_op_i, req1_a1_i, req1_a0_i,
    output rsp0_ready_i, rsp1_ready_i,
    output alu_r_i, alu_sign_i,
    input  req0_ready_o, req1_ready_o,
    input  rsp0_valid_o, rsp1_valid_o, rsp_r_o, rsp_sign_o,
    input  alu_a1_o, alu_a0_o, alu_add_o, alu_sub_o
  );
endinterface

// File: rtl/alu8_arbiter.sv
// Round-robin share of one edge-strobed add/sub ALU between two requesters.
// Accept at T, response valid from T+4; response held until its ready, no grants meanwhile.
module alu8_arbiter #(
  parameter int WIDTH      = 8,
  parameter bit PRIO_RESET = 1'b0
) (
  input logic           clk_i,
  input logic           rst_i,
  alu8_arbiter_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SETUP   = 3'd1,
    S_EXEC    = 3'd2,
    S_CAPTURE = 3'd3,
    S_RESP    = 3'd4
  } state_t;

  state_t           state_q;
  state_t           state_d;

  logic             grant_vld;
  logic             grant_port;
  logic             sel_op;
  logic [WIDTH-1:0] sel_a1;
  logic [WIDTH-1:0] sel_a0;
  logic             rsp_take;

  logic             op_q;
  logic             owner_q;
  logic             last_q;
  logic [WIDTH-1:0] a1_q;
  logic [WIDTH-1:0] a0_q;
  logic [WIDTH-1:0] r_q;
  logic             sign_q;

  logic             add_d;
  logic             sub_d;
  logic             rsp0_vld_d;
  logic             rsp1_vld_d;
  logic             add_q;
  logic             sub_q;
  logic             rsp0_vld_q;
  logic             rsp1_vld_q;

  // Arbitration only happens in IDLE; on a tie the port not granted last wins.
  always_comb begin
    grant_vld  = 1'b0;
    grant_port = 1'b0;
    if (state_q == S_IDLE) begin
      if (bus.req0_valid_i && bus.req1_valid_i) begin
        grant_vld  = 1'b1;
        grant_port = ~last_q;
      end else if (bus.req0_valid_i) begin
        grant_vld  = 1'b1;
        grant_port = 1'b0;
      end else if (bus.req1_valid_i) begin
        grant_vld  = 1'b1;
        grant_port = 1'b1;
      end
    end
  end

  always_comb begin
    sel_op = bus.req0_op_i;
    sel_a1 = bus.req0_a1_i;
    sel_a0 = bus.req0_a0_i;
    if (grant_port) begin
      sel_op = bus.req1_op_i;
      sel_a1 = bus.req1_a1_i;
      sel_a0 = bus.req1_a0_i;
    end
  end

  assign rsp_take = owner_q ? bus.rsp1_ready_i : bus.rsp0_ready_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Strobes and response valids are decoded from the next state and registered,
  // so the edge-sensitive ALU inputs never see combinational glitches.
  always_comb begin
    state_d    = state_q;
    add_d      = 1'b0;
    sub_d      = 1'b0;
    rsp0_vld_d = 1'b0;
    rsp1_vld_d = 1'b0;
    case (state_q)
      S_IDLE:    if (grant_vld) state_d = S_SETUP;
      S_SETUP:   state_d = S_EXEC;
      S_EXEC:    state_d = S_CAPTURE;
      S_CAPTURE: state_d = S_RESP;
      S_RESP:    if (rsp_take) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
    if (state_d == S_EXEC) begin
      add_d = ~op_q;
      sub_d = op_q;
    end
    if (state_d == S_RESP) begin
      rsp0_vld_d = ~owner_q;
      rsp1_vld_d = owner_q;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      add_q      <= 1'b0;
      sub_q      <= 1'b0;
      rsp0_vld_q <= 1'b0;
      rsp1_vld_q <= 1'b0;
    end else begin
      add_q      <= add_d;
      sub_q      <= sub_d;
      rsp0_vld_q <= rsp0_vld_d;
      rsp1_vld_q <= rsp1_vld_d;
    end
  end

  // Operands change only at a grant, which is never concurrent with a strobe.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      op_q    <= 1'b0;
      owner_q <= 1'b0;
      last_q  <= ~PRIO_RESET;
      a1_q    <= '0;
      a0_q    <= '0;
      r_q     <= '0;
      sign_q  <= 1'b0;
    end else begin
      if (grant_vld) begin
        op_q    <= sel_op;
        owner_q <= grant_port;
        last_q  <= grant_port;
        a1_q    <= sel_a1;
        a0_q    <= sel_a0;
      end
      if (state_q == S_CAPTURE) begin
        r_q    <= bus.alu_r_i;
        sign_q <= bus.alu_sign_i;
      end
    end
  end

  // The accept pulse is combinational; gating with reset keeps it low while held in reset.
  assign bus.req0_ready_o = grant_vld & ~grant_port & ~rst_i;
  assign bus.req1_ready_o = grant_vld &  grant_port & ~rst_i;

  assign bus.rsp0_valid_o = rsp0_vld_q;
  assign bus.rsp1_valid_o = rsp1_vld_q;
  assign bus.rsp_r_o      = r_q;
  assign bus.rsp_sign_o   = sign_q;

  assign bus.alu_a1_o     = a1_q;
  assign bus.alu_a0_o     = a0_q;
  assign bus.alu_add_o    = add_q;
  assign bus.alu_sub_o    = sub_q;

endmodule

// File: tb/tb_alu8_arbiter.sv
// Bench for alu8_arbiter: directed scenarios plus randomized traffic against a
// cycle-level reference model of grant order, latency and arithmetic.
module tb_alu8_arbiter;
  localparam int W    = 8;
  localparam bit PRIO = 1'b0;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;

  alu8_arbiter_if #(.WIDTH(W)) bus ();

  alu8_arbiter #(.WIDTH(W), .PRIO_RESET(PRIO)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // External ALU: computes on the rising edge of whichever strobe fires.
  logic [W-1:0] strobe_a1;
  logic [W-1:0] strobe_a0;
  logic         last_was_sub = 1'b0;
  always @(posedge bus.alu_add_o or posedge bus.alu_sub_o) begin
    strobe_a1    = bus.alu_a1_o;
    strobe_a0    = bus.alu_a0_o;
    last_was_sub = bus.alu_sub_o;
    if (bus.alu_sub_o) bus.alu_r_i = bus.alu_a1_o - bus.alu_a0_o;
    else               bus.alu_r_i = bus.alu_a1_o + bus.alu_a0_o;
    bus.alu_sign_i = bus.alu_r_i[W-1];
  end

  // Strobe exclusivity and operand stability while a strobe is high.
  always @(negedge clk) begin
    if (bus.alu_add_o || bus.alu_sub_o) begin
      n_checks++;
      if (bus.alu_add_o && bus.alu_sub_o)
        $display("FAIL strobe_excl: add=%0b sub=%0b, required not both 1", bus.alu_add_o, bus.alu_sub_o);
      else n_pass++;
      n_checks++;
      if (bus.alu_a1_o !== strobe_a1 || bus.alu_a0_o !== strobe_a0)
        $display("FAIL operand_stable: a1=%0h a0=%0h, required %0h %0h", bus.alu_a1_o, bus.alu_a0_o, strobe_a1, strobe_a0);
      else n_pass++;
    end
  end

  function automatic logic [8:0] ref_alu(input logic op, input logic [7:0] a1, input logic [7:0] a0);
    int v;
    v = op ? (int'(a1) - int'(a0)) : (int'(a1) + int'(a0));
    if (v < 0)   v += 256;
    if (v > 255) v -= 256;
    return {(v >= 128), 8'(v)};
  endfunction

  task automatic idle_inputs();
    bus.req0_valid_i = 1'b0; bus.req0_op_i = 1'b0; bus.req0_a1_i = '0; bus.req0_a0_i = '0;
    bus.req1_valid_i = 1'b0; bus.req1_op_i = 1'b0; bus.req1_a1_i = '0; bus.req1_a0_i = '0;
    bus.rsp0_ready_i = 1'b0; bus.rsp1_ready_i = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic drive_req(input int port, input logic vld, input logic op, input logic [7:0] a1, input logic [7:0] a0);
    if (port == 0) begin
      bus.req0_valid_i = vld; bus.req0_op_i = op; bus.req0_a1_i = a1; bus.req0_a0_i = a0;
    end else begin
      bus.req1_valid_i = vld; bus.req1_op_i = op; bus.req1_a1_i = a1; bus.req1_a0_i = a0;
    end
  endtask

  // Presents one request and returns the cycle its ready pulse was seen (-1 if never).
  task automatic issue(input int port, input logic op, input logic [7:0] a1, input logic [7:0] a0, output int acc);
    @(posedge clk); #1;
    drive_req(port, 1'b1, op, a1, a0);
    acc = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if ((port == 0) ? bus.req0_ready_o : bus.req1_ready_o) begin
        acc = cyc;
        break;
      end
    end
    @(posedge clk); #1;
    drive_req(port, 1'b0, op, a1, a0);
  endtask

  task automatic wait_rsp(input int port, output int at, output logic [7:0] r, output logic s, output logic other_seen);
    at = -1; r = '0; s = 1'b0; other_seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if ((port == 0) ? bus.rsp1_valid_o : bus.rsp0_valid_o) other_seen = 1'b1;
      if ((port == 0) ? bus.rsp0_valid_o : bus.rsp1_valid_o) begin
        at = cyc; r = bus.rsp_r_o; s = bus.rsp_sign_o;
        break;
      end
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    bus.req0_valid_i = 1'b1;
    bus.req1_valid_i = 1'b1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_checks++; if (bus.req0_ready_o !== 1'b0) $display("FAIL reset_ready0: got %0b want 0", bus.req0_ready_o); else n_pass++;
    n_checks++; if (bus.req1_ready_o !== 1'b0) $display("FAIL reset_ready1: got %0b want 0", bus.req1_ready_o); else n_pass++;
    n_checks++; if (bus.rsp0_valid_o !== 1'b0) $display("FAIL reset_rsp0: got %0b want 0", bus.rsp0_valid_o); else n_pass++;
    n_checks++; if (bus.rsp1_valid_o !== 1'b0) $display("FAIL reset_rsp1: got %0b want 0", bus.rsp1_valid_o); else n_pass++;
    n_checks++; if ({bus.alu_add_o, bus.alu_sub_o} !== 2'b00) $display("FAIL reset_strobes: got %b want 00", {bus.alu_add_o, bus.alu_sub_o}); else n_pass++;
    n_checks++; if ({bus.alu_a1_o, bus.alu_a0_o} !== 16'h0000) $display("FAIL reset_operands: got %h want 0000", {bus.alu_a1_o, bus.alu_a0_o}); else n_pass++;
    n_checks++; if ({bus.rsp_sign_o, bus.rsp_r_o} !== 9'h000) $display("FAIL reset_result: got %h want 000", {bus.rsp_sign_o, bus.rsp_r_o}); else n_pass++;
    idle_inputs();
    @(posedge clk); #1 rst = 1'b0;
  endtask

  // One transaction on one port, checking latency, value, flag, strobe type and port isolation.
  task automatic test_single(input string name, input int port, input logic op, input logic [7:0] a1, input logic [7:0] a0);
    int acc, at;
    logic [7:0] r;
    logic s, other;
    logic [8:0] exp;
    exp = ref_alu(op, a1, a0);
    bus.rsp0_ready_i = 1'b1;
    bus.rsp1_ready_i = 1'b1;
    issue(port, op, a1, a0, acc);
    n_checks++; if (acc < 0) $display("FAIL %s_accept: no ready pulse within 20 cycles", name); else n_pass++;
    wait_rsp(port, at, r, s, other);
    n_checks++; if (at !== acc + 4) $display("FAIL %s_latency: rsp at cycle %0d, want %0d", name, at, acc + 4); else n_pass++;
    n_checks++; if (r !== exp[7:0]) $display("FAIL %s_r: got %h want %h", name, r, exp[7:0]); else n_pass++;
    n_checks++; if (s !== exp[8]) $display("FAIL %s_sign: got %0b want %0b", name, s, exp[8]); else n_pass++;
    n_checks++; if (other !== 1'b0) $display("FAIL %s_other_port: other rsp valid seen=%0b want 0", name, other); else n_pass++;
    n_checks++; if (last_was_sub !== op) $display("FAIL %s_strobe_kind: sub=%0b want %0b", name, last_was_sub, op); else n_pass++;
    @(negedge clk);
    n_checks++; if ({bus.rsp1_valid_o, bus.rsp0_valid_o} !== 2'b00) $display("FAIL %s_rsp_drop: got %b want 00", name, {bus.rsp1_valid_o, bus.rsp0_valid_o}); else n_pass++;
    n_checks++; if (bus.rsp_r_o !== exp[7:0]) $display("FAIL %s_r_hold: got %h want %h", name, bus.rsp_r_o, exp[7:0]); else n_pass++;
  endtask

  task automatic test_alternate();
    int gport[$];
    int gcyc[$];
    do_reset();
    bus.rsp0_ready_i = 1'b1;
    bus.rsp1_ready_i = 1'b1;
    @(posedge clk); #1;
    drive_req(0, 1'b1, 1'b0, 8'h10, 8'h01);
    drive_req(1, 1'b1, 1'b1, 8'h20, 8'h02);
    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      if (bus.req0_ready_o || bus.req1_ready_o) begin
        gport.push_back(bus.req1_ready_o ? 1 : 0);
        gcyc.push_back(cyc);
      end
      if (bus.rsp0_valid_o) begin
        n_checks++; if (bus.rsp_r_o !== 8'h11) $display("FAIL alt_rsp0_r: got %h want 11", bus.rsp_r_o); else n_pass++;
      end
      if (bus.rsp1_valid_o) begin
        n_checks++; if (bus.rsp_r_o !== 8'h1E) $display("FAIL alt_rsp1_r: got %h want 1e", bus.rsp_r_o); else n_pass++;
      end
    end
    @(posedge clk); #1;
    idle_inputs();
    repeat (6) @(posedge clk);
    n_checks++;
    if (gport.size() < 4) begin
      $display("FAIL alt_grant_count: got %0d want >= 4", gport.size());
    end else begin
      n_pass++;
      for (int i = 0; i < 4; i++) begin
        n_checks++; if (gport[i] !== (int'(PRIO) + i) % 2) $display("FAIL alt_order[%0d]: got %0d want %0d", i, gport[i], (int'(PRIO) + i) % 2); else n_pass++;
        if (i > 0) begin
          n_checks++; if (gcyc[i] - gcyc[i-1] !== 5) $display("FAIL alt_spacing[%0d]: got %0d want 5", i, gcyc[i] - gcyc[i-1]); else n_pass++;
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int acc, at;
    logic [7:0] r;
    logic s, other;
    do_reset();
    bus.rsp1_ready_i = 1'b1;
    @(posedge clk); #1;
    drive_req(0, 1'b1, 1'b0, 8'h40, 8'h05);
    drive_req(1, 1'b1, 1'b1, 8'h09, 8'h0A);
    @(negedge clk);
    acc = cyc;
    n_checks++; if ({bus.req1_ready_o, bus.req0_ready_o} !== 2'b01) $display("FAIL bp_first_grant: got %b want 01", {bus.req1_ready_o, bus.req0_ready_o}); else n_pass++;
    @(posedge clk); #1;
    drive_req(0, 1'b0, 1'b0, 8'h40, 8'h05);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      n_checks++; if (bus.req1_ready_o !== 1'b0) $display("FAIL bp_no_grant[%0d]: ready1=%0b want 0", k, bus.req1_ready_o); else n_pass++;
      if (k >= 4) begin
        n_checks++; if (bus.rsp0_valid_o !== 1'b1) $display("FAIL bp_rsp0_hold[%0d]: got %0b want 1", k, bus.rsp0_valid_o); else n_pass++;
        n_checks++; if (bus.rsp_r_o !== 8'h45) $display("FAIL bp_r_stable[%0d]: got %h want 45", k, bus.rsp_r_o); else n_pass++;
      end
    end
    @(posedge clk); #1 bus.rsp0_ready_i = 1'b1;
    @(negedge clk);
    n_checks++; if ({bus.rsp0_valid_o, bus.req1_ready_o} !== 2'b10) $display("FAIL bp_handshake: rsp0/ready1=%b want 10", {bus.rsp0_valid_o, bus.req1_ready_o}); else n_pass++;
    @(posedge clk); #1 bus.rsp0_ready_i = 1'b0;
    @(negedge clk);
    n_checks++; if (bus.req1_ready_o !== 1'b1 || cyc !== acc + 8) $display("FAIL bp_second_grant: ready1=%0b at cycle %0d, want 1 at %0d", bus.req1_ready_o, cyc, acc + 8); else n_pass++;
    acc = cyc;
    @(posedge clk); #1;
    drive_req(1, 1'b0, 1'b1, 8'h09, 8'h0A);
    wait_rsp(1, at, r, s, other);
    n_checks++; if (at !== acc + 4 || r !== 8'hFF || s !== 1'b1) $display("FAIL bp_rsp1: at %0d r=%h s=%0b, want %0d ff 1", at, r, s, acc + 4); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int acc, at;
    logic found, seen;
    logic [7:0] r;
    logic s, other;
    bus.rsp0_ready_i = 1'b1;
    bus.rsp1_ready_i = 1'b1;
    @(posedge clk); #1;
    drive_req(0, 1'b1, 1'b0, 8'h22, 8'h11);
    @(negedge clk);
    n_checks++; if (bus.req0_ready_o !== 1'b1) $display("FAIL rmid_accept: ready0=%0b want 1", bus.req0_ready_o); else n_pass++;
    @(posedge clk); #1;
    drive_req(0, 1'b0, 1'b0, 8'h22, 8'h11);
    found = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (bus.alu_add_o) begin found = 1'b1; break; end
    end
    n_checks++; if (found !== 1'b1) $display("FAIL rmid_exec: add strobe not seen within 5 cycles"); else n_pass++;
    rst = 1'b1;
    #1;
    n_checks++; if ({bus.alu_add_o, bus.alu_sub_o} !== 2'b00) $display("FAIL rmid_async_strobe: got %b want 00", {bus.alu_add_o, bus.alu_sub_o}); else n_pass++;
    @(posedge clk); #1 rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.rsp0_valid_o || bus.rsp1_valid_o) seen = 1'b1;
    end
    n_checks++; if (seen !== 1'b0) $display("FAIL rmid_no_rsp: response seen after abort, want none"); else n_pass++;
    issue(1, 1'b0, 8'h30, 8'h0F, acc);
    wait_rsp(1, at, r, s, other);
    n_checks++; if (acc < 0 || at !== acc + 4 || r !== 8'h3F || s !== 1'b0) $display("FAIL rmid_recover: acc %0d at %0d r=%h s=%0b, want r=3f s=0 at acc+4", acc, at, r, s); else n_pass++;
  endtask

  task automatic test_random();
    logic       pend [2];
    logic       pop  [2];
    logic [7:0] pa1  [2];
    logic [7:0] pa0  [2];
    logic       outstanding, owner, model_last, gp;
    logic [1:0] exp_g, exp_v;
    logic [8:0] exp;
    int         acc, ngrants;
    do_reset();
    for (int p = 0; p < 2; p++) begin pend[p] = 1'b0; pop[p] = 1'b0; pa1[p] = '0; pa0[p] = '0; end
    outstanding = 1'b0; owner = 1'b0; model_last = ~PRIO; acc = 0; ngrants = 0; exp = '0;
    for (int c = 0; c < 400; c++) begin
      @(posedge clk); #1;
      for (int p = 0; p < 2; p++) begin
        if (pend[p] && $urandom_range(0, 9) == 0) pend[p] = 1'b0;
        else if (!pend[p] && $urandom_range(0, 2) == 0) begin
          pend[p] = 1'b1;
          pop[p]  = 1'($urandom_range(0, 1));
          pa1[p]  = 8'($urandom);
          pa0[p]  = 8'($urandom);
        end
        drive_req(p, pend[p], pop[p], pa1[p], pa0[p]);
      end
      bus.rsp0_ready_i = 1'($urandom_range(0, 1));
      bus.rsp1_ready_i = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (!outstanding) begin
        gp    = (pend[0] && pend[1]) ? ~model_last : pend[1];
        exp_g = (pend[0] || pend[1]) ? (gp ? 2'b10 : 2'b01) : 2'b00;
        n_checks++; if ({bus.req1_ready_o, bus.req0_ready_o} !== exp_g) $display("FAIL rnd_grant@%0d: got %b want %b", cyc, {bus.req1_ready_o, bus.req0_ready_o}, exp_g); else n_pass++;
        n_checks++; if ({bus.rsp1_valid_o, bus.rsp0_valid_o} !== 2'b00) $display("FAIL rnd_idle_rsp@%0d: got %b want 00", cyc, {bus.rsp1_valid_o, bus.rsp0_valid_o}); else n_pass++;
        if (exp_g != 2'b00) begin
          outstanding = 1'b1; owner = gp; model_last = gp; acc = cyc; ngrants++;
          exp = ref_alu(pop[gp], pa1[gp], pa0[gp]);
          pend[gp] = 1'b0;
        end
      end else begin
        n_checks++; if ({bus.req1_ready_o, bus.req0_ready_o} !== 2'b00) $display("FAIL rnd_busy_grant@%0d: got %b want 00", cyc, {bus.req1_ready_o, bus.req0_ready_o}); else n_pass++;
        exp_v = (cyc >= acc + 4) ? (owner ? 2'b10 : 2'b01) : 2'b00;
        n_checks++; if ({bus.rsp1_valid_o, bus.rsp0_valid_o} !== exp_v) $display("FAIL rnd_rsp_valid@%0d: got %b want %b", cyc, {bus.rsp1_valid_o, bus.rsp0_valid_o}, exp_v); else n_pass++;
        if (exp_v != 2'b00) begin
          n_checks++; if ({bus.rsp_sign_o, bus.rsp_r_o} !== exp) $display("FAIL rnd_result@%0d: got %h want %h", cyc, {bus.rsp_sign_o, bus.rsp_r_o}, exp); else n_pass++;
          if (owner ? bus.rsp1_ready_i : bus.rsp0_ready_i) outstanding = 1'b0;
        end
      end
    end
    @(posedge clk); #1;
    idle_inputs();
    bus.rsp0_ready_i = 1'b1;
    bus.rsp1_ready_i = 1'b1;
    repeat (8) @(posedge clk);
    n_checks++; if (ngrants < 20) $display("FAIL rnd_activity: only %0d grants, want >= 20", ngrants); else n_pass++;
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_single("add", 0, 1'b0, 8'h05, 8'h03);
    test_single("sub", 1, 1'b1, 8'h03, 8'h05);
    test_alternate();
    test_backpressure();
    test_reset_mid();
    test_single("ovf", 0, 1'b0, 8'h7F, 8'h01);
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

endmodule
